shift_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one combinational ShiftLR barrel shifter among NREQ independent requesters.
- Each cycle it picks at most one pending request and drives the shifter's X/S/LEFT/LOG inputs from that request.
- It captures Z into a one-entry output register, tagged with the requester ID.
- Sits between the functional-unit issue ports and the shared shifter instance; the shifter itself stays outside this block.

---
 rtl/shift_arbiter.sv | 109 ++++++++++
 tb/tb_shift_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end that shares one external ShiftLR
// barrel shifter among NREQ requesters. The granted request drives the
// shifter combinationally and its Z output is captured into a one-entry
// result register tagged with the requester index.
module shift_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_data,
  input  logic [5*NREQ-1:0]    req_amt,
  input  logic [NREQ-1:0]      req_left,
  input  logic [NREQ-1:0]      req_log,
  output logic [31:0]          sh_x,
  output logic [4:0]           sh_s,
  output logic                 sh_left,
  output logic                 sh_log,
  input  logic [31:0]          sh_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id
);

  // Result register and round-robin pointer
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_data;
  logic [IDW-1:0]  r_rsp_id;
  logic [IDW-1:0]  r_rr_ptr;

  // Per-requester fields unpacked from the flat buses
  logic [31:0]     w_x [NREQ];
  logic [4:0]      w_s [NREQ];

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_any;
  logic            w_can_accept;
  logic            w_accept;
  logic [IDW-1:0]  w_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_x[gi] = req_data[32*gi +: 32];
      assign w_s[gi] = req_amt[5*gi +: 5];
    end
  endgenerate

  // Scan from r_rr_ptr upward, wrapping at NREQ, and take the first pending request
  always_comb begin
    logic [IDW:0] v_cand;
    logic         v_found;
    v_cand    = '0;
    v_found   = 1'b0;
    w_grant   = '0;
    w_gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_cand = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (v_cand >= (IDW+1)'(NREQ)) begin
        v_cand = v_cand - (IDW+1)'(NREQ);
      end
      if (!v_found && req_valid[v_cand[IDW-1:0]]) begin
        v_found                       = 1'b1;
        w_gnt_idx                     = v_cand[IDW-1:0];
        w_grant[v_cand[IDW-1:0]]      = 1'b1;
      end
    end
  end

  assign w_any        = |w_grant;
  assign w_can_accept = ~r_rsp_valid | rsp_ready;
  assign w_accept     = w_any & w_can_accept;
  assign req_ready    = w_grant & {NREQ{w_can_accept}};

  // Pointer moves just past the winner; wrap explicitly so non-power-of-two NREQ stays in range
  assign w_ptr_next = (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + IDW'(1);

  // The shifter sees the winner even while stalled; the result is simply not captured then
  assign sh_x    = w_any ? w_x[w_gnt_idx]      : 32'd0;
  assign sh_s    = w_any ? w_s[w_gnt_idx]      : 5'd0;
  assign sh_left = w_any ? req_left[w_gnt_idx] : 1'b0;
  assign sh_log  = w_any ? req_log[w_gnt_idx]  : 1'b0;

  // Capture on accept (replacing a draining result), clear valid on a bare drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= sh_z;
      r_rsp_id    <= w_gnt_idx;
      r_rr_ptr    <= w_ptr_next;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed checks of shift_arbiter (NREQ=4 and NREQ=3)
// plus a short random regression, with the shared shifter modelled here.
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // NREQ=4 instance
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_data = '0;
  logic [19:0]  req_amt = '0;
  logic [3:0]   req_left = '0;
  logic [3:0]   req_log = '0;
  logic [31:0]  sh_x, sh_z, rsp_data;
  logic [4:0]   sh_s;
  logic         sh_left, sh_log, rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;

  // NREQ=3 instance
  logic [2:0]   b_req_valid = '0;
  logic [2:0]   b_req_ready;
  logic [95:0]  b_req_data = '0;
  logic [14:0]  b_req_amt = '0;
  logic [2:0]   b_req_left = '0;
  logic [2:0]   b_req_log = '0;
  logic [31:0]  b_sh_x, b_sh_z, b_rsp_data;
  logic [4:0]   b_sh_s;
  logic         b_sh_left, b_sh_log, b_rsp_valid;
  logic         b_rsp_ready = 1'b1;
  logic [1:0]   b_rsp_id;

  function automatic logic [31:0] shf(input logic [31:0] x, input logic [4:0] s,
                                      input logic l, input logic g);
    if (l)      return x << s;
    else if (g) return x >> s;
    else        return 32'($signed(x) >>> s);
  endfunction

  assign sh_z   = shf(sh_x, sh_s, sh_left, sh_log);
  assign b_sh_z = shf(b_sh_x, b_sh_s, b_sh_left, b_sh_log);

  shift_arbiter #(.NREQ(4), .IDW(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt), .req_left(req_left), .req_log(req_log),
    .sh_x(sh_x), .sh_s(sh_s), .sh_left(sh_left), .sh_log(sh_log), .sh_z(sh_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id));

  shift_arbiter #(.NREQ(3), .IDW(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_data(b_req_data), .req_amt(b_req_amt), .req_left(b_req_left), .req_log(b_req_log),
    .sh_x(b_sh_x), .sh_s(b_sh_s), .sh_left(b_sh_left), .sh_log(b_sh_log), .sh_z(b_sh_z),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_id(b_rsp_id));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic [31:0] x, input logic [4:0] s,
                         input logic l, input logic g);
    req_data[32*i +: 32] = x;
    req_amt[5*i +: 5]    = s;
    req_left[i]          = l;
    req_log[i]           = g;
    req_valid[i]         = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Random regression state
  logic [31:0] pend_exp [4];
  int issued   = 0;
  int accepted = 0;

  task automatic rnd_step(input bit gen);
    logic [3:0]  acc;
    logic [31:0] x;
    logic [4:0]  s;
    logic        l, g;
    int          idx;
    if (gen) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          x = $urandom; s = 5'($urandom_range(0, 31));
          l = 1'($urandom_range(0, 1)); g = 1'($urandom_range(0, 1));
          set_req(i, x, s, l, g);
          pend_exp[i] = shf(x, s, l, g);
          issued++;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    acc = req_valid & req_ready;
    check("rnd_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    tick();
    if (acc != 4'd0) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (acc[i]) idx = i;
      check("rnd_valid", 32'(rsp_valid), 32'd1);
      check("rnd_id", 32'(rsp_id), 32'(idx));
      check("rnd_data", rsp_data, pend_exp[idx]);
      req_valid[idx] = 1'b0;
      accepted++;
    end
  endtask

  logic [31:0] exp_rr [4];

  initial begin
    exp_rr[0] = 32'h2222_2222; exp_rr[1] = 32'h4444_4444;
    exp_rr[2] = 32'h6666_6666; exp_rr[3] = 32'h8888_8888;

    // Reset then idle
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("rst_data", rsp_data, 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_valid", 32'(rsp_valid), 32'd0);
      check("idle_ready", 32'(req_ready), 32'd0);
      check("idle_shx", sh_x, 32'd0);
    end

    // Single ops on requester 0: arithmetic right, logical right, left
    rsp_ready = 1'b1;
    set_req(0, 32'h8000_00F0, 5'd4, 1'b0, 1'b0);
    @(negedge clk);
    check("op_ready", 32'(req_ready), 32'b0001);
    check("op_shx", sh_x, 32'h8000_00F0);
    tick();
    check("asr_valid", 32'(rsp_valid), 32'd1);
    check("asr_data", rsp_data, 32'hF800_000F);
    check("asr_id", 32'(rsp_id), 32'd0);
    set_req(0, 32'h8000_00F0, 5'd4, 1'b0, 1'b1);
    tick();
    check("lsr_data", rsp_data, 32'h0800_000F);
    set_req(0, 32'h8000_00F0, 5'd4, 1'b1, 1'b0);
    tick();
    check("lsl_data", rsp_data, 32'h0000_0F00);
    req_valid = '0;
    tick();
    check("drain_valid", 32'(rsp_valid), 32'd0);
    check("drain_hold", rsp_data, 32'h0000_0F00);

    // Round robin with all four requesters valid
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 32'h1111_1111 * 32'(i + 1), 5'd1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_valid", 32'(rsp_valid), 32'd1);
      check("rr_id", 32'(rsp_id), 32'(k % 4));
      check("rr_data", rsp_data, exp_rr[k % 4]);
    end

    // Backpressure: result held, nothing granted, pointer unchanged
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd3);
      check("bp_data", rsp_data, 32'h8888_8888);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(req_ready), 32'b0001);
    tick();
    check("bp_release_id", 32'(rsp_id), 32'd0);
    check("bp_release_data", rsp_data, 32'h2222_2222);

    // Reset mid-operation returns pointer to 0 and drops the result
    req_valid = 4'b0100;
    tick();
    check("mid_id", 32'(rsp_id), 32'd2);
    req_valid = 4'b1010;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("mid_rst_ready", 32'(req_ready), 32'b0010);
    tick();
    check("mid_after_id", 32'(rsp_id), 32'd1);
    check("mid_after_data", rsp_data, 32'h4444_4444);
    req_valid = '0;
    tick();

    // NREQ=3 pointer wrap
    b_req_data[63:32] = 32'hF000_0000; b_req_amt[9:5]   = 5'd4; b_req_left[1] = 1'b0; b_req_log[1] = 1'b0;
    b_req_data[95:64] = 32'h0000_00FF; b_req_amt[14:10] = 5'd8; b_req_left[2] = 1'b1; b_req_log[2] = 1'b0;
    b_req_valid = 3'b010;
    @(negedge clk);
    check("w3_ready0", 32'(b_req_ready), 32'b010);
    tick();
    check("w3_id0", 32'(b_rsp_id), 32'd1);
    check("w3_data0", b_rsp_data, 32'hFF00_0000);
    b_req_valid = 3'b110;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("w3_ready", 32'(b_req_ready), (k % 2 == 0) ? 32'b100 : 32'b010);
      tick();
      check("w3_id", 32'(b_rsp_id), (k % 2 == 0) ? 32'd2 : 32'd1);
      check("w3_data", b_rsp_data, (k % 2 == 0) ? 32'h0000_FF00 : 32'hFF00_0000);
    end
    b_req_valid = '0;

    // Random regression with random backpressure
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 300; c++) rnd_step(1'b1);
    for (int c = 0; c < 20 && req_valid != 4'd0; c++) rnd_step(1'b0);
    check("rnd_all_done", 32'(req_valid), 32'd0);
    check("rnd_once", 32'(accepted), 32'(issued));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
